// File: rtl/operand_pkg.sv
// ---------------------------------------------------------------------------
// operand_pkg
// Shared types for the operand feeder in front of the 4-bit registered adder
// pair (c = b + d, a = b + c).
//   OPERAND_W      : operand width, must match the downstream adder
//   operand_pair_t : one buffered {b, d} operand pair
//   feeder_state_t : feeder control state (IDLE / RUN / HOLD)
// ---------------------------------------------------------------------------
package operand_pkg;

    localparam int OPERAND_W = 4;

    typedef struct packed {
        logic [OPERAND_W-1:0] b;
        logic [OPERAND_W-1:0] d;
    } operand_pair_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } feeder_state_t;

endpackage : operand_pkg

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with no look-ahead: full/empty/count all come straight
// from registered pointers and count, so they only change after a clock edge.
// The head entry is readable combinationally on rd_data; the consumer is
// expected to register it.
//   Clock   : rising-edge clock
//   Reset   : asynchronous active-high reset (pointers and count to 0)
//   wr_en   : write request, ignored when full
//   wr_data : data written at the write pointer
//   rd_en   : read request (pops the head), ignored when empty
//   rd_data : current head entry
//   full    : count == DEPTH
//   empty   : count == 0
//   count   : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    logic wr_ok;
    logic rd_ok;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

    // Gating here keeps the storage safe even if a caller ignores full/empty.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_comb begin
        count_next = count_reg;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage carries no reset: stale contents are unreachable once the
    // pointers and count are cleared. Writes happen only on an accepted
    // enqueue, so undriven wr_data never lands in the array.
    always_ff @(posedge Clock) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_reg];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule : sync_fifo

// File: rtl/operand_feeder.sv
// ---------------------------------------------------------------------------
// operand_feeder
// Buffers {b, d} operand pairs from a valid/ready producer and feeds one
// registered pair per permitted cycle to the downstream registered adder.
//   Clock      : rising-edge clock
//   Reset      : asynchronous active-high reset
//   in_valid   : producer offers in_b/in_d this cycle
//   in_b, in_d : operand pair to enqueue
//   in_ready   : FIFO can accept (depends on registered fill only)
//   issue_en   : downstream permits a new pair this cycle
//   b, d       : registered operands to the adder
//   op_valid   : b/d were loaded by an issue on the last edge
//   issued_cnt : pairs issued since reset (wraps)
//   fill       : current FIFO occupancy
// ---------------------------------------------------------------------------
module operand_feeder
    import operand_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [WIDTH-1:0]         in_d,
    output logic                     in_ready,
    input  logic                     issue_en,
    output logic [WIDTH-1:0]         b,
    output logic [WIDTH-1:0]         d,
    output logic                     op_valid,
    output logic [CNT_W-1:0]         issued_cnt,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int FILL_W = $clog2(DEPTH) + 1;

    operand_pair_t wr_pair;
    operand_pair_t head_pair;
    logic          fifo_full;
    logic          fifo_empty;
    logic [FILL_W-1:0] fifo_count;

    logic enq;
    logic iss;
    logic last_issue;

    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] d_reg;
    logic             op_valid_reg;
    logic [CNT_W-1:0] issued_cnt_reg;

    feeder_state_t state_reg;
    feeder_state_t state_next;

    assign wr_pair.b = in_b;
    assign wr_pair.d = in_d;

    sync_fifo #(
        .WIDTH ($bits(operand_pair_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clock   (Clock),
        .Reset   (Reset),
        .wr_en   (enq),
        .wr_data (wr_pair),
        .rd_en   (iss),
        .rd_data (head_pair),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // in_ready looks only at the registered occupancy: an issue in the same
    // cycle does not open a slot until the next edge.
    assign in_ready = !fifo_full;
    assign enq      = in_valid && in_ready;
    // An empty FIFO cannot issue, even if an enqueue lands on this edge;
    // the new pair becomes visible on b/d one edge later at the earliest.
    assign iss      = issue_en && !fifo_empty;

    // The final entry leaves and nothing replaces it.
    assign last_issue = iss && !enq && (fifo_count == FILL_W'(1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (enq) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_issue) begin
                    state_next = IDLE;
                end else if (!issue_en) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (issue_en) begin
                    state_next = last_issue ? IDLE : RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Output register: b/d only load on an issue and otherwise hold, so the
    // downstream adder keeps seeing the last pair while op_valid drops.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            b_reg          <= '0;
            d_reg          <= '0;
            op_valid_reg   <= 1'b0;
            issued_cnt_reg <= '0;
        end else begin
            op_valid_reg <= iss;
            if (iss) begin
                b_reg          <= head_pair.b;
                d_reg          <= head_pair.d;
                issued_cnt_reg <= issued_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign b          = b_reg;
    assign d          = d_reg;
    assign op_valid   = op_valid_reg;
    assign issued_cnt = issued_cnt_reg;
    assign fill       = fifo_count;

endmodule : operand_feeder

// File: tb/tb_operand_feeder.sv
// ---------------------------------------------------------------------------
// tb_operand_feeder
// Directed bench for operand_feeder. Accepted offers push the expected pair
// into a scoreboard queue; an independent monitor pops and compares each
// time op_valid is seen. Directed checks cover reset, latency, backpressure,
// steady streaming, counter wrap and reset mid-operation.
// ---------------------------------------------------------------------------
module tb_operand_feeder;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             Clock = 1'b0;
    logic             Reset = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_b = '0;
    logic [WIDTH-1:0] in_d = '0;
    logic             in_ready;
    logic             issue_en = 1'b0;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] d;
    logic             op_valid;
    logic [CNT_W-1:0] issued_cnt;
    logic [$clog2(DEPTH):0] fill;

    // Stand-in for the downstream adder's c = b + d register.
    logic [WIDTH-1:0] c_tb = '0;

    logic [2*WIDTH-1:0] sb [$];
    int n_vec = 0;
    int n_err = 0;
    int n_issue = 0;

    operand_feeder #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .in_valid   (in_valid),
        .in_b       (in_b),
        .in_d       (in_d),
        .in_ready   (in_ready),
        .issue_en   (issue_en),
        .b          (b),
        .d          (d),
        .op_valid   (op_valid),
        .issued_cnt (issued_cnt),
        .fill       (fill)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) c_tb <= WIDTH'(b + d);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Offer one pair at the current negedge; record it if it will be taken.
    task automatic offer(input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] vd);
        in_valid = 1'b1;
        in_b     = vb;
        in_d     = vd;
        if (in_ready === 1'b1) begin
            sb.push_back({vb, vd});
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        in_valid = 1'b0;
        issue_en = 1'b0;
        Reset    = 1'b1;
        sb.delete();
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    // Monitor: every presented pair must be the oldest outstanding one.
    always @(negedge Clock) begin
        if (Reset === 1'b0 && op_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_issue: got b=%0d d=%0d, expected no issue", b, d);
            end else begin
                logic [2*WIDTH-1:0] exp_pair;
                exp_pair = sb.pop_front();
                n_issue++;
                $display("issue %0d: b=%0d d=%0d (expected b=%0d d=%0d)",
                         n_issue, b, d, exp_pair[2*WIDTH-1:WIDTH], exp_pair[WIDTH-1:0]);
                check("issue_b", 32'(b), 32'(exp_pair[2*WIDTH-1:WIDTH]));
                check("issue_d", 32'(d), 32'(exp_pair[WIDTH-1:0]));
            end
        end
    end

    initial begin
        int accepted;
        int guard;

        // ---- Reset then idle: asynchronous, no clock edge needed ----
        #2 Reset = 1'b1;
        #1;
        check("rst_b", 32'(b), 0);
        check("rst_d", 32'(d), 0);
        check("rst_op_valid", 32'(op_valid), 0);
        check("rst_fill", 32'(fill), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_issued_cnt", 32'(issued_cnt), 0);
        @(negedge Clock);
        Reset = 1'b0;

        // ---- Single pair (3,5) with issue_en high ----
        issue_en = 1'b1;
        offer(4'd3, 4'd5);
        @(negedge Clock);
        in_valid = 1'b0;
        check("single_no_fallthrough", 32'(op_valid), 0);
        check("single_fill1", 32'(fill), 1);
        @(negedge Clock);
        check("single_op_valid", 32'(op_valid), 1);
        check("single_b", 32'(b), 3);
        check("single_d", 32'(d), 5);
        check("single_cnt", 32'(issued_cnt), 1);
        @(negedge Clock);
        check("single_c", 32'(c_tb), 8);
        check("single_op_valid_drop", 32'(op_valid), 0);
        check("single_b_hold", 32'(b), 3);

        // ---- Fill and backpressure ----
        issue_en = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            offer(WIDTH'(k), WIDTH'(k));
            @(negedge Clock);
        end
        check("full_fill", 32'(fill), 4);
        check("full_in_ready", 32'(in_ready), 0);
        offer(4'd9, 4'd9);
        @(negedge Clock);
        in_valid = 1'b0;
        check("full_5th_rejected", 32'(fill), 4);
        check("hold_op_valid", 32'(op_valid), 0);
        issue_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clock);
            check("drain_op_valid", 32'(op_valid), 1);
        end
        @(negedge Clock);
        check("drain_done_op_valid", 32'(op_valid), 0);
        check("drain_done_fill", 32'(fill), 0);
        check("drain_cnt", 32'(issued_cnt), 5);

        // ---- Simultaneous enqueue/issue at fill = 2 for 20 cycles ----
        do_reset();
        offer(4'd10, 4'd1);
        @(negedge Clock);
        offer(4'd11, 4'd2);
        @(negedge Clock);
        check("stream_prefill", 32'(fill), 2);
        issue_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            offer(WIDTH'(i), WIDTH'(15 - i));
            @(negedge Clock);
            check("stream_fill", 32'(fill), 2);
        end
        check("stream_cnt", 32'(issued_cnt), 20);
        in_valid = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        check("stream_drained", 32'(fill), 0);

        // ---- 300 pairs: counter and pointer wrap ----
        do_reset();
        accepted = 0;
        guard    = 0;
        while (accepted < 300 && guard < 2000) begin
            issue_en = (guard % 7 != 3);
            if (in_ready === 1'b1) accepted++;
            offer(WIDTH'(accepted), WIDTH'(accepted * 5 + 1));
            @(negedge Clock);
            guard++;
        end
        check("wrap_accepted", 32'(accepted), 300);
        in_valid = 1'b0;
        issue_en = 1'b1;
        guard = 0;
        while (fill != 0 && guard < 50) begin
            @(negedge Clock);
            guard++;
        end
        check("wrap_drain_timeout", 32'(fill), 0);
        @(negedge Clock);
        check("wrap_cnt", 32'(issued_cnt), 44);

        // ---- Reset mid-operation ----
        do_reset();
        for (int k = 0; k < 3; k++) begin
            offer(WIDTH'(k + 5), WIDTH'(k + 1));
            @(negedge Clock);
        end
        issue_en = 1'b1;
        offer(4'd8, 4'd4);
        @(negedge Clock);
        in_valid = 1'b0;
        issue_en = 1'b0;
        check("pre_rst_fill", 32'(fill), 3);
        check("pre_rst_op_valid", 32'(op_valid), 1);
        #2 Reset = 1'b1;
        #1;
        check("mid_rst_b", 32'(b), 0);
        check("mid_rst_d", 32'(d), 0);
        check("mid_rst_op_valid", 32'(op_valid), 0);
        check("mid_rst_fill", 32'(fill), 0);
        check("mid_rst_cnt", 32'(issued_cnt), 0);
        check("mid_rst_in_ready", 32'(in_ready), 1);
        sb.delete();
        @(negedge Clock);
        Reset = 1'b0;
        issue_en = 1'b1;
        offer(4'd12, 4'd7);
        @(negedge Clock);
        in_valid = 1'b0;
        @(negedge Clock);
        check("post_rst_op_valid", 32'(op_valid), 1);
        check("post_rst_b", 32'(b), 12);
        check("post_rst_d", 32'(d), 7);
        check("post_rst_cnt", 32'(issued_cnt), 1);
        @(negedge Clock);
        check("post_rst_no_stale", 32'(op_valid), 0);
        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_operand_feeder
